decoder_mac_pipe: RTL

Pipelined, parametrised signed multiply-accumulate unit for the decoder datapath. It is the successor to the single-cycle combinational signed multiplier. It adds a configurable register pipeline, dot-product accumulation framed by a `last` flag, round-and-saturate output scaling, and a valid/ready handshake on both sides. It sits between the weight/activation fetch logic and the activation stage of each decoder layer.

---
 rtl/decoder_mac_pkg.sv | 40 ++++
 rtl/decoder_mul_pipe.sv | 58 +++++
 rtl/decoder_mac_pipe.sv | 138 +++++++++++++
 3 files changed

// File: rtl/decoder_mac_pkg.sv
// Shared types and arithmetic helpers for the decoder MAC datapath.
// Helpers work on a fixed 64-bit signed container; callers cast to/from their widths.
package decoder_mac_pkg;

  localparam int unsigned NUM_STAGE_MIN = 1;
  localparam int unsigned NUM_STAGE_MAX = 4;
  localparam int unsigned CALC_W        = 64;

  typedef logic signed [CALC_W-1:0] calc_t;

  typedef struct packed {
    calc_t value;
    logic  ovf;
  } sat_t;

  // Clamp value into the signed range of 'width' bits; ovf flags a clamp.
  function automatic sat_t sat_signed(input calc_t value, input int unsigned width);
    calc_t hi;
    calc_t lo;
    sat_t  r;
    hi      = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
    lo      = -hi - calc_t'(1);
    r.value = value;
    r.ovf   = 1'b0;
    if (value > hi) begin
      r.value = hi;
      r.ovf   = 1'b1;
    end else if (value < lo) begin
      r.value = lo;
      r.ovf   = 1'b1;
    end
    return r;
  endfunction

  // Round half toward +inf, then arithmetic shift right.
  function automatic calc_t round_shift(input calc_t value, input int unsigned shift);
    return (value + (calc_t'(1) <<< (shift - 1))) >>> shift;
  endfunction

endpackage

// File: rtl/decoder_mul_pipe.sv
// Signed multiplier followed by STAGES enable-gated registers carrying the
// product plus its (valid, last) sideband; synthesis retimes the multiplier.
module decoder_mul_pipe #(
  parameter int unsigned A_WIDTH = 16,
  parameter int unsigned B_WIDTH = 8,
  parameter int unsigned STAGES  = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               en_i,
  input  logic                               valid_i,
  input  logic                               last_i,
  input  logic signed [A_WIDTH-1:0]          a_i,
  input  logic signed [B_WIDTH-1:0]          b_i,
  output logic signed [A_WIDTH+B_WIDTH-1:0]  prod_o,
  output logic                               valid_o,
  output logic                               last_o
);

  localparam int unsigned P_W = A_WIDTH + B_WIDTH;

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;
  logic signed [P_W-1:0] prod_d;
  logic signed [P_W-1:0] prod_q [STAGES];
  logic [STAGES-1:0]     valid_q;
  logic [STAGES-1:0]     last_q;

  always_comb begin
    a_ext  = {{B_WIDTH{a_i[A_WIDTH-1]}}, a_i};
    b_ext  = {{A_WIDTH{b_i[B_WIDTH-1]}}, b_i};
    prod_d = a_ext * b_ext;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        prod_q[i] <= '0;
      end
      valid_q <= '0;
      last_q  <= '0;
    end else if (en_i) begin
      prod_q[0]  <= prod_d;
      valid_q[0] <= valid_i;
      last_q[0]  <= last_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        prod_q[i]  <= prod_q[i-1];
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign prod_o  = prod_q[STAGES-1];
  assign valid_o = valid_q[STAGES-1];
  assign last_o  = last_q[STAGES-1];

endmodule

// File: rtl/decoder_mac_pipe.sv
// Pipelined signed dot-product MAC: multiply pipe, saturating accumulator,
// final-sum register, then round/saturate into a valid/ready output register.
module decoder_mac_pipe
  import decoder_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = 16,
  parameter int unsigned DIN1_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DOUT_WIDTH = 16,
  parameter int unsigned NUM_STAGE  = 2,
  parameter int unsigned FRAC_SHIFT = 7
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_ovf
);

  localparam int unsigned PROD_W = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned STAGES =
      (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
      (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX : NUM_STAGE;

  logic                     stall;
  logic signed [PROD_W-1:0] mul_prod;
  logic                     mul_valid;
  logic                     mul_last;

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         first_q, first_d;
  logic                         acc_ovf_q, acc_ovf_d;
  logic                         fin_valid_q, fin_valid_d;
  logic signed [ACC_WIDTH-1:0]  fin_sum_q, fin_sum_d;
  logic                         fin_ovf_q, fin_ovf_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                         dout_ovf_q, dout_ovf_d;

  calc_t acc_base;
  sat_t  acc_sat;
  sat_t  out_sat;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  decoder_mul_pipe #(
    .A_WIDTH (DIN0_WIDTH),
    .B_WIDTH (DIN1_WIDTH),
    .STAGES  (STAGES)
  ) u_mul (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .en_i    (in_ready),
    .valid_i (in_valid),
    .last_i  (in_last),
    .a_i     (din0),
    .b_i     (din1),
    .prod_o  (mul_prod),
    .valid_o (mul_valid),
    .last_o  (mul_last)
  );

  // Accumulate and round/saturate sit in separate stages so each closes alone.
  always_comb begin
    acc_d       = acc_q;
    first_d     = first_q;
    acc_ovf_d   = acc_ovf_q;
    fin_valid_d = fin_valid_q;
    fin_sum_d   = fin_sum_q;
    fin_ovf_d   = fin_ovf_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    dout_ovf_d  = dout_ovf_q;

    if (first_q) acc_base = '0;
    else         acc_base = CALC_W'(acc_q);
    acc_sat = sat_signed(acc_base + CALC_W'(mul_prod), ACC_WIDTH);
    out_sat = sat_signed(round_shift(CALC_W'(fin_sum_q), FRAC_SHIFT), DOUT_WIDTH);

    if (!stall) begin
      fin_valid_d = mul_valid & mul_last;
      if (mul_valid) begin
        first_d = mul_last;
        if (mul_last) begin
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          fin_sum_d = ACC_WIDTH'(acc_sat.value);
          fin_ovf_d = acc_ovf_q | acc_sat.ovf;
        end else begin
          acc_d     = ACC_WIDTH'(acc_sat.value);
          acc_ovf_d = acc_ovf_q | acc_sat.ovf;
        end
      end
      // A pending final sum replaces a just-accepted result without a bubble.
      out_valid_d = fin_valid_q;
      if (fin_valid_q) begin
        dout_d     = DOUT_WIDTH'(out_sat.value);
        dout_ovf_d = fin_ovf_q | out_sat.ovf;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      acc_ovf_q   <= 1'b0;
      fin_valid_q <= 1'b0;
      fin_sum_q   <= '0;
      fin_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dout_ovf_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      acc_ovf_q   <= acc_ovf_d;
      fin_valid_q <= fin_valid_d;
      fin_sum_q   <= fin_sum_d;
      fin_ovf_q   <= fin_ovf_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      dout_ovf_q  <= dout_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign dout_ovf  = dout_ovf_q;

endmodule
